mmul_dispatch: RTL

- Sits directly downstream of the instruction source and upstream of the matrix-multiply compute core.
- Accepts instructions (op, dest, src1, src2) over valid/ready and buffers them in a small FIFO.
- Enforces in-order issue. MMUL_D (dependent) instructions wait until all outstanding operations have completed; MMUL_ND instructions may issue back-to-back up to an outstanding-operation limit.
- Tracks completions from the core and reports idle/busy status to the top level.

---
 rtl/mmul_dispatch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mmul_dispatch.sv
// In-order issue buffer between the instruction source and the matmul core.
// Define MMUL_DISPATCH_STATS_EN to add the issue/stall statistics counters.
module mmul_dispatch #(
  parameter int ADDR_W          = 16,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_op,
  input  logic [ADDR_W-1:0] in_dest,
  input  logic [ADDR_W-1:0] in_src1,
  input  logic [ADDR_W-1:0] in_src2,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              iss_op,
  output logic [ADDR_W-1:0] iss_dest,
  output logic [ADDR_W-1:0] iss_src1,
  output logic [ADDR_W-1:0] iss_src2,
  output logic              iss_valid,
  input  logic              iss_ready,
  input  logic              cmp_done,
  output logic [2:0]        outstanding,
  output logic              idle,
  output logic              err_underflow
`ifdef MMUL_DISPATCH_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_dep_stall,
  output logic [31:0]       stat_cap_stall
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0] MAX_O = 3'(MAX_OUTSTANDING);

  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] dest;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } state_t;

  instr_t           mem [FIFO_DEPTH];
  instr_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  state_t           state;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             issue;
  logic [2:0]       out_nxt;

  assign fifo_empty = (count == '0);
  assign in_ready   = reset && (count != FULL_CNT);
  assign push       = in_valid && in_ready;
  assign iss_valid  = (state == HOLD) && (outstanding < MAX_O);
  assign issue      = iss_valid && iss_ready;
  assign head       = mem[rd_ptr];
  assign idle       = fifo_empty && (state == IDLE)
                   && (outstanding == '0);

  // The head is only consumed when it moves into the output register.
  assign pop = !fifo_empty
            && ((state == IDLE) || ((state == HOLD) && issue));

  always_comb begin
    out_nxt = outstanding;
    unique case ({issue, cmp_done})
      2'b10:   out_nxt = outstanding + 3'd1;
      2'b01:   if (outstanding != '0) out_nxt = outstanding - 3'd1;
      default: out_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_dest, in_src1, in_src2};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      state         <= IDLE;
      outstanding   <= '0;
      err_underflow <= 1'b0;
      iss_op        <= 1'b0;
      iss_dest      <= '0;
      iss_src1      <= '0;
      iss_src2      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      outstanding <= out_nxt;
      if (cmp_done && !issue && (outstanding == '0))
        err_underflow <= 1'b1;
      if (pop) begin
        iss_op   <= head.op;
        iss_dest <= head.dest;
        iss_src1 <= head.src1;
        iss_src2 <= head.src2;
      end
      unique case (state)
        IDLE:
          if (pop) state <= head.op ? DRAIN : HOLD;
        DRAIN:
          // Completion in this cycle already counts toward the drain.
          if (out_nxt == '0) state <= HOLD;
        HOLD:
          if (issue) begin
            if (pop) state <= head.op ? DRAIN : HOLD;
            else     state <= IDLE;
          end
        default:
          state <= IDLE;
      endcase
    end
  end

`ifdef MMUL_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_issued    <= '0;
      stat_dep_stall <= '0;
      stat_cap_stall <= '0;
    end else begin
      if (issue && (stat_issued != '1))
        stat_issued <= stat_issued + 32'd1;
      if ((state == DRAIN) && (stat_dep_stall != '1))
        stat_dep_stall <= stat_dep_stall + 32'd1;
      if ((state == HOLD) && (outstanding == MAX_O)
          && (stat_cap_stall != '1))
        stat_cap_stall <= stat_cap_stall + 32'd1;
    end
  end
`endif

endmodule
